id_ex_stage: RTL
================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register feeding the EX-stage ALU. Decodes the 5-bit ALUoperation and operand sources from the ID instruction, then registers them.
//  In EX it forwards operands from EX/MEM and MEM/WB, and drives the ALU A, B and ALUoperation inputs.
//  Detects load-use hazards: stalls IF/ID and injects a bubble.
// PARAMETERS
//  XLEN      32    datapath width; only 32 is supported
//  RESET_PC  0     pc value held in the register after reset
// PORTS
//  clk            in   1     rising-edge clock
//  rst            in   1     synchronous, active-high reset
//  id_valid       in   1     ID slot holds a real instruction
//  id_pc          in   32    pc of the ID instruction
//  id_instr       in   32    raw instruction word
//  id_rs1_data    in   32    regfile read port 1
//  id_rs2_data    in   32    regfile read port 2
//  id_imm         in   32    sign-extended immediate from immgen
//  flush          in   1     branch/jump redirect resolved in EX
//  exm_rd/exm_we  in   5/1   EX/MEM destination and write enable
//  exm_is_load    in   1     EX/MEM holds a load; its data is not yet available
//  exm_result     in   32    EX/MEM ALU result
//  wb_rd/wb_we    in   5/1   MEM/WB destination and write enable
//  wb_data        in   32    MEM/WB write-back data
//  stall_id       out  1     hold PC and IF/ID this cycle
//  ex_valid       out  1     EX slot valid
//  ex_alu_op      out  5     ALUoperation to the ALU
//  ex_alu_a       out  32    ALU A, after forwarding and source selection
//  ex_alu_b       out  32    ALU B, after forwarding and source selection
//  ex_rs2_fwd     out  32    forwarded rs2, used as store data
//  ex_rd/ex_we    out  5/1   destination register and write enable
//  ex_mem_rd      out  1     ex_mem_wr  out  1     load / store in EX
//  ex_illegal     out  1     unrecognised opcode/funct; EX treats it as a nop
// BEHAVIOUR
//  - Register update priority per edge: rst > flush > load-use bubble > load from ID.
//  - On rst, flush or bubble the register holds a nop:
//    - valid=0, alu_op=00000, rd=0, we=0, mem_rd=0, mem_wr=0, illegal=0.
//    - After rst, pc=RESET_PC and all data fields are 0.
//  - Latency: 1 cycle from ID to EX outputs. Forwarding muxes are combinational in EX.
//  - stall_id = id_valid & ex_valid & ex_mem_rd & ex_rd!=0 & (ex_rd==id_rs1 | (ex_rd==id_rs2 & id uses rs2)).
//    - It is combinational and is forced to 0 while flush=1; flush wins.
//  - ALU op encoding:
//    - add 00000, sub 01, and 02, or 03, xor 04, sll 05, srl 06, sra 07
//    - mul 08, mulh 09, mulhu 0A, mulhsu 0B, div 0C, divu 0D, rem 0E, remu 0F
//    - slt 10, sltu 11
//  - Decode by opcode:
//    - OP: funct7 0000000 selects base ops, 0100000 selects sub/sra, 0000001 selects the M extension.
//    - OP-IMM: B=imm; srai only when imm[11:5]=0100000.
//    - LUI: A=0, B=imm, add.
//    - AUIPC: A=pc, B=imm, add.
//    - JAL/JALR: A=pc, B=4, add.
//    - LOAD/STORE: A=rs1, B=imm, add.
//    - BRANCH: beq/bne use sub; blt/bge use slt; bltu/bgeu use sltu; we=0.
//    - Any other encoding sets illegal=1 and we=0.
//  - Forwarding per source:
//    - EX/MEM when exm_we & exm_rd!=0 & exm_rd==rs. This has priority.
//    - Otherwise MEM/WB when wb_we & wb_rd!=0 & wb_rd==rs.
//    - Otherwise the registered regfile value. x0 is never forwarded.
//  - Shift ops 00101..00111: ex_alu_b = {27'b0, b[4:0]}, because the ALU shifts by the full B value.
//  - Reset applied mid-stall clears the bubble/stall state; stall_id is 0 on the next cycle.
//  - Simultaneous flush and stall: the nop is loaded and stall_id=0.
// STRUCTURE
//  - riscv_pkg holds the opcode localparams, the ALUOP_* 5-bit codes and the SRC_A (RS1/PC/ZERO) and SRC_B (RS2/IMM/FOUR) selects.
//  - One sub-module, alu_op_decode, decodes id_instr into alu_op, src_a, src_b, we, mem_rd, mem_wr, illegal and uses_rs2. It is combinational.
//  - Top level holds the pipeline register, hazard detection and forwarding muxes.
// TESTING
//  - add x3,x1,x2 with rs1=5, rs2=7 -> next cycle alu_op=00000, A=5, B=7, ex_rd=3, ex_we=1.
//  - sub x4,x3,x1 with exm_rd=3, exm_result=12 and wb_rd=3, wb_data=99 -> A=12 (EX/MEM wins), alu_op=00001.
//  - lw x5,0(x1) then add x6,x5,x5 -> stall_id=1 for 1 cycle, then a bubble (ex_valid=0), then A=B=load value via MEM/WB.
//  - srai x7,x1,3 with x1=0x80000000 -> alu_op=00111, B=3; slli with imm=0x43 -> B=3.
//  - mulhsu, remu and bltu -> alu_op 01011, 01111 and 10001; bltu gives ex_we=0.
//  - flush=1 together with a load-use stall -> ex_valid=0 and stall_id=0; rst mid-stream -> all outputs reach their reset values.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32IM decode constants for the ID/EX stage.
// Contents:
//   OPC_*      7-bit major opcodes
//   ALUOP_*    5-bit ALUoperation codes understood by the EX-stage ALU
//   src_a_e    ALU A source select (RS1 / PC / ZERO)
//   src_b_e    ALU B source select (RS2 / IMM / FOUR)
//   id_ex_t    contents of the ID/EX pipeline register
//   base_alu_op  funct3 -> ALU op for the base integer ops (OP and OP-IMM)
package riscv_pkg;

   localparam int RV_XLEN = 32;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;
   localparam logic [6:0] F7_MEXT = 7'b0000001;

   localparam logic [4:0] ALUOP_ADD    = 5'h00;
   localparam logic [4:0] ALUOP_SUB    = 5'h01;
   localparam logic [4:0] ALUOP_AND    = 5'h02;
   localparam logic [4:0] ALUOP_OR     = 5'h03;
   localparam logic [4:0] ALUOP_XOR    = 5'h04;
   localparam logic [4:0] ALUOP_SLL    = 5'h05;
   localparam logic [4:0] ALUOP_SRL    = 5'h06;
   localparam logic [4:0] ALUOP_SRA    = 5'h07;
   localparam logic [4:0] ALUOP_MUL    = 5'h08;
   localparam logic [4:0] ALUOP_MULH   = 5'h09;
   localparam logic [4:0] ALUOP_MULHU  = 5'h0A;
   localparam logic [4:0] ALUOP_MULHSU = 5'h0B;
   localparam logic [4:0] ALUOP_DIV    = 5'h0C;
   localparam logic [4:0] ALUOP_DIVU   = 5'h0D;
   localparam logic [4:0] ALUOP_REM    = 5'h0E;
   localparam logic [4:0] ALUOP_REMU   = 5'h0F;
   localparam logic [4:0] ALUOP_SLT    = 5'h10;
   localparam logic [4:0] ALUOP_SLTU   = 5'h11;

   typedef enum logic [1:0] {
      SRC_A_RS1  = 2'd0,
      SRC_A_PC   = 2'd1,
      SRC_A_ZERO = 2'd2
   } src_a_e;

   typedef enum logic [1:0] {
      SRC_B_RS2  = 2'd0,
      SRC_B_IMM  = 2'd1,
      SRC_B_FOUR = 2'd2
   } src_b_e;

   typedef struct packed {
      logic                 valid;
      logic [RV_XLEN-1:0]   pc;
      logic [4:0]           alu_op;
      src_a_e               src_a;
      src_b_e               src_b;
      logic [4:0]           rs1;
      logic [4:0]           rs2;
      logic [RV_XLEN-1:0]   rs1_data;
      logic [RV_XLEN-1:0]   rs2_data;
      logic [RV_XLEN-1:0]   imm;
      logic [4:0]           rd;
      logic                 we;
      logic                 mem_rd;
      logic                 mem_wr;
      logic                 illegal;
   } id_ex_t;

   function automatic logic [4:0] base_alu_op(input logic [2:0] funct3);
      logic [4:0] op;
      case (funct3)
         3'b000:  op = ALUOP_ADD;
         3'b001:  op = ALUOP_SLL;
         3'b010:  op = ALUOP_SLT;
         3'b011:  op = ALUOP_SLTU;
         3'b100:  op = ALUOP_XOR;
         3'b101:  op = ALUOP_SRL;
         3'b110:  op = ALUOP_OR;
         default: op = ALUOP_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decoder from a raw RV32IM instruction word to the ALU
// operation, operand sources and control bits carried into EX.
// Ports:
//   instr_i     raw instruction word
//   alu_op_o    5-bit ALUoperation
//   src_a_o     ALU A source, src_b_o ALU B source
//   we_o        writes rd; mem_rd_o load; mem_wr_o store
//   illegal_o   unrecognised opcode/funct (control bits forced to a nop)
//   uses_rs2_o  instruction reads rs2 (used by load-use detection)
//   rd_o/rs1_o/rs2_o  register index fields
module alu_op_decode
   import riscv_pkg::*;
(
   input  logic [31:0] instr_i,
   output logic [4:0]  alu_op_o,
   output src_a_e      src_a_o,
   output src_b_e      src_b_o,
   output logic        we_o,
   output logic        mem_rd_o,
   output logic        mem_wr_o,
   output logic        illegal_o,
   output logic        uses_rs2_o,
   output logic [4:0]  rd_o,
   output logic [4:0]  rs1_o,
   output logic [4:0]  rs2_o
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;

   assign opcode = instr_i[6:0];
   assign funct3 = instr_i[14:12];
   assign funct7 = instr_i[31:25];
   assign rd_o   = instr_i[11:7];
   assign rs1_o  = instr_i[19:15];
   assign rs2_o  = instr_i[24:20];

   always_comb begin
      alu_op_o   = ALUOP_ADD;
      src_a_o    = SRC_A_RS1;
      src_b_o    = SRC_B_RS2;
      we_o       = 1'b0;
      mem_rd_o   = 1'b0;
      mem_wr_o   = 1'b0;
      illegal_o  = 1'b0;
      uses_rs2_o = 1'b0;

      case (opcode)
         OPC_OP: begin
            we_o       = 1'b1;
            uses_rs2_o = 1'b1;
            case (funct7)
               F7_BASE: alu_op_o = base_alu_op(funct3);
               F7_ALT: begin
                  case (funct3)
                     3'b000:  alu_op_o  = ALUOP_SUB;
                     3'b101:  alu_op_o  = ALUOP_SRA;
                     default: illegal_o = 1'b1;
                  endcase
               end
               F7_MEXT: begin
                  case (funct3)
                     3'b000:  alu_op_o = ALUOP_MUL;
                     3'b001:  alu_op_o = ALUOP_MULH;
                     3'b010:  alu_op_o = ALUOP_MULHSU;
                     3'b011:  alu_op_o = ALUOP_MULHU;
                     3'b100:  alu_op_o = ALUOP_DIV;
                     3'b101:  alu_op_o = ALUOP_DIVU;
                     3'b110:  alu_op_o = ALUOP_REM;
                     default: alu_op_o = ALUOP_REMU;
                  endcase
               end
               default: illegal_o = 1'b1;
            endcase
         end
         OPC_OP_IMM: begin
            we_o     = 1'b1;
            src_b_o  = SRC_B_IMM;
            alu_op_o = base_alu_op(funct3);
            // funct7 field is imm[11:5]; only the shift-right form looks at it
            if (funct3 == 3'b101 && funct7 == F7_ALT)
               alu_op_o = ALUOP_SRA;
         end
         OPC_LUI: begin
            we_o    = 1'b1;
            src_a_o = SRC_A_ZERO;
            src_b_o = SRC_B_IMM;
         end
         OPC_AUIPC: begin
            we_o    = 1'b1;
            src_a_o = SRC_A_PC;
            src_b_o = SRC_B_IMM;
         end
         OPC_JAL, OPC_JALR: begin
            // link value pc+4 is computed by the ALU
            we_o    = 1'b1;
            src_a_o = SRC_A_PC;
            src_b_o = SRC_B_FOUR;
         end
         OPC_LOAD: begin
            we_o     = 1'b1;
            mem_rd_o = 1'b1;
            src_b_o  = SRC_B_IMM;
         end
         OPC_STORE: begin
            mem_wr_o   = 1'b1;
            uses_rs2_o = 1'b1;
            src_b_o    = SRC_B_IMM;
         end
         OPC_BRANCH: begin
            uses_rs2_o = 1'b1;
            case (funct3)
               3'b000, 3'b001: alu_op_o  = ALUOP_SUB;
               3'b100, 3'b101: alu_op_o  = ALUOP_SLT;
               3'b110, 3'b111: alu_op_o  = ALUOP_SLTU;
               default:        illegal_o = 1'b1;
            endcase
         end
         default: illegal_o = 1'b1;
      endcase

      // An illegal instruction travels down the pipe as a nop.
      if (illegal_o) begin
         alu_op_o   = ALUOP_ADD;
         we_o       = 1'b0;
         mem_rd_o   = 1'b0;
         mem_wr_o   = 1'b0;
         uses_rs2_o = 1'b0;
      end
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and EX-stage
// operand forwarding, driving the ALU A/B/ALUoperation inputs.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   id_*                ID-stage instruction, pc, regfile reads, immediate
//   flush               redirect resolved in EX; squashes the ID instruction
//   exm_* / wb_*        EX/MEM and MEM/WB write-back info for forwarding
//   stall_id            hold PC and IF/ID this cycle (load-use)
//   ex_valid, ex_alu_op, ex_alu_a, ex_alu_b   EX slot and ALU inputs
//   ex_rs2_fwd          forwarded rs2 (store data)
//   ex_rd, ex_we, ex_mem_rd, ex_mem_wr, ex_illegal   EX control
module id_ex_stage
   import riscv_pkg::*;
#(
   parameter int          XLEN     = 32,   // only 32 is supported
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            id_valid,
   input  logic [XLEN-1:0] id_pc,
   input  logic [31:0]     id_instr,
   input  logic [XLEN-1:0] id_rs1_data,
   input  logic [XLEN-1:0] id_rs2_data,
   input  logic [XLEN-1:0] id_imm,
   input  logic            flush,
   input  logic [4:0]      exm_rd,
   input  logic            exm_we,
   input  logic            exm_is_load,
   input  logic [XLEN-1:0] exm_result,
   input  logic [4:0]      wb_rd,
   input  logic            wb_we,
   input  logic [XLEN-1:0] wb_data,
   output logic            stall_id,
   output logic            ex_valid,
   output logic [4:0]      ex_alu_op,
   output logic [XLEN-1:0] ex_alu_a,
   output logic [XLEN-1:0] ex_alu_b,
   output logic [XLEN-1:0] ex_rs2_fwd,
   output logic [4:0]      ex_rd,
   output logic            ex_we,
   output logic            ex_mem_rd,
   output logic            ex_mem_wr,
   output logic            ex_illegal
);

   // ---------------- ID decode ----------------
   logic [4:0] dec_alu_op;
   src_a_e     dec_src_a;
   src_b_e     dec_src_b;
   logic       dec_we, dec_mem_rd, dec_mem_wr, dec_illegal, dec_uses_rs2;
   logic [4:0] dec_rd, dec_rs1, dec_rs2;

   alu_op_decode u_dec (
      .instr_i    (id_instr),
      .alu_op_o   (dec_alu_op),
      .src_a_o    (dec_src_a),
      .src_b_o    (dec_src_b),
      .we_o       (dec_we),
      .mem_rd_o   (dec_mem_rd),
      .mem_wr_o   (dec_mem_wr),
      .illegal_o  (dec_illegal),
      .uses_rs2_o (dec_uses_rs2),
      .rd_o       (dec_rd),
      .rs1_o      (dec_rs1),
      .rs2_o      (dec_rs2)
   );

   id_ex_t ex_q, ex_d;
   logic   id_we;

   // ---------------- load-use hazard ----------------
   // A load in EX has no data until MEM completes, so a dependent ID
   // instruction is held one cycle while a bubble goes into EX.
   always_comb begin
      stall_id = id_valid & ex_q.valid & ex_q.mem_rd & (ex_q.rd != 5'd0) &
                 ((ex_q.rd == dec_rs1) | ((ex_q.rd == dec_rs2) & dec_uses_rs2));
      if (flush)
         stall_id = 1'b0;
   end

   // ---------------- next-state of the pipeline register ----------------
   assign id_we = dec_we & id_valid;

   always_comb begin
      ex_d.valid    = id_valid;
      ex_d.pc       = id_pc;
      ex_d.alu_op   = dec_alu_op;
      ex_d.src_a    = dec_src_a;
      ex_d.src_b    = dec_src_b;
      ex_d.rs1      = dec_rs1;
      ex_d.rs2      = dec_rs2;
      ex_d.rs1_data = id_rs1_data;
      ex_d.rs2_data = id_rs2_data;
      ex_d.imm      = id_imm;
      // rd only carries meaning for writers; zero it otherwise so stores and
      // branches never look like producers to later hazard/forwarding logic
      ex_d.rd       = id_we ? dec_rd : 5'd0;
      ex_d.we       = id_we;
      ex_d.mem_rd   = dec_mem_rd & id_valid;
      ex_d.mem_wr   = dec_mem_wr & id_valid;
      ex_d.illegal  = dec_illegal & id_valid;
      // flush and load-use bubble both insert a nop
      if (flush || stall_id) begin
         ex_d.valid   = 1'b0;
         ex_d.alu_op  = ALUOP_ADD;
         ex_d.rd      = 5'd0;
         ex_d.we      = 1'b0;
         ex_d.mem_rd  = 1'b0;
         ex_d.mem_wr  = 1'b0;
         ex_d.illegal = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_q    <= '0;
         ex_q.pc <= RESET_PC;
      end else begin
         ex_q <= ex_d;
      end
   end

   // ---------------- EX-stage forwarding ----------------
   // Index 0 is rs1, index 1 is rs2. EX/MEM beats MEM/WB; x0 never forwards.
   // A load sitting in EX/MEM only has its address in exm_result, so it is
   // never a forwarding source (load-use stalling keeps that case away).
   logic [4:0]      rs_idx  [2];
   logic [XLEN-1:0] rs_data [2];
   logic [XLEN-1:0] rs_fwd  [2];

   assign rs_idx[0]  = ex_q.rs1;
   assign rs_idx[1]  = ex_q.rs2;
   assign rs_data[0] = ex_q.rs1_data;
   assign rs_data[1] = ex_q.rs2_data;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
         always_comb begin
            if (exm_we && !exm_is_load && exm_rd != 5'd0 && exm_rd == rs_idx[gi])
               rs_fwd[gi] = exm_result;
            else if (wb_we && wb_rd != 5'd0 && wb_rd == rs_idx[gi])
               rs_fwd[gi] = wb_data;
            else
               rs_fwd[gi] = rs_data[gi];
         end
      end
   endgenerate

   // ---------------- ALU operand selection ----------------
   logic [XLEN-1:0] alu_b_raw;

   always_comb begin
      case (ex_q.src_a)
         SRC_A_PC:   ex_alu_a = ex_q.pc;
         SRC_A_ZERO: ex_alu_a = '0;
         default:    ex_alu_a = rs_fwd[0];
      endcase
   end

   always_comb begin
      case (ex_q.src_b)
         SRC_B_IMM:  alu_b_raw = ex_q.imm;
         SRC_B_FOUR: alu_b_raw = XLEN'(4);
         default:    alu_b_raw = rs_fwd[1];
      endcase
   end

   // The ALU shifts by its whole B operand, so trim shift amounts to 5 bits
   // here (also strips the funct7 bits that ride in an I-type immediate).
   always_comb begin
      ex_alu_b = alu_b_raw;
      if (ex_q.alu_op == ALUOP_SLL || ex_q.alu_op == ALUOP_SRL || ex_q.alu_op == ALUOP_SRA)
         ex_alu_b = {{(XLEN-5){1'b0}}, alu_b_raw[4:0]};
   end

   assign ex_rs2_fwd = rs_fwd[1];
   assign ex_valid   = ex_q.valid;
   assign ex_alu_op  = ex_q.alu_op;
   assign ex_rd      = ex_q.rd;
   assign ex_we      = ex_q.we;
   assign ex_mem_rd  = ex_q.mem_rd;
   assign ex_mem_wr  = ex_q.mem_wr;
   assign ex_illegal = ex_q.illegal;

endmodule
